// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path sampled on a 16x oversample enable.
// Assembles LSB-first bytes and hands them off via a sticky rdy/rdy_clr
// handshake with sticky frame-error and overrun flags.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BPW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SCW-1:0] CNT_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] CNT_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BPW-1:0] BP_LAST  = BPW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [SCW-1:0]       sample_cnt, sample_cnt_d;
  logic [BPW-1:0]       bitpos, bitpos_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [DATA_BITS-1:0] dout_d;
  logic                 rdy_d, frame_err_d, overrun_d;
  logic                 rx_meta, rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bitpos     <= '0;
      shift      <= '0;
      dout       <= '0;
      rdy        <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state      <= state_d;
      sample_cnt <= sample_cnt_d;
      bitpos     <= bitpos_d;
      shift      <= shift_d;
      dout       <= dout_d;
      rdy        <= rdy_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      rx_busy    <= (state_d != IDLE);
    end
  end

  // Next-state and datapath; a flag set in the same cycle as rdy_clr wins
  always_comb begin
    state_d      = state;
    sample_cnt_d = sample_cnt;
    bitpos_d     = bitpos;
    shift_d      = shift;
    dout_d       = dout;
    rdy_d        = rdy & ~rdy_clr;
    frame_err_d  = frame_err & ~rdy_clr;
    overrun_d    = overrun & ~rdy_clr;

    case (state)
      IDLE: begin
        if (clken && !rx_s) begin
          state_d      = START;
          sample_cnt_d = '0;
        end
      end
      START: begin
        if (clken) begin
          if (sample_cnt == CNT_MID) begin
            // Start bit still low at its midpoint: real frame, else a glitch
            sample_cnt_d = '0;
            if (!rx_s) begin
              state_d  = DATA;
              bitpos_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt + SCW'(1);
          end
        end
      end
      DATA: begin
        if (clken) begin
          if (sample_cnt == CNT_LAST) begin
            shift_d[bitpos] = rx_s;
            sample_cnt_d    = '0;
            if (bitpos == BP_LAST) begin
              state_d = STOP;
            end else begin
              bitpos_d = bitpos + BPW'(1);
            end
          end else begin
            sample_cnt_d = sample_cnt + SCW'(1);
          end
        end
      end
      STOP: begin
        if (clken) begin
          if (sample_cnt == CNT_LAST) begin
            // Leave at mid stop bit to give the next start edge half a bit of margin
            state_d      = IDLE;
            sample_cnt_d = '0;
            if (rx_s) begin
              dout_d = shift;
              rdy_d  = 1'b1;
              if (rdy && !rdy_clr) begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt + SCW'(1);
          end
        end
      end
      default: begin
        state_d      = IDLE;
        sample_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver: directed frames, clken every 4 clk_in.
module tb_uart_receiver;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       clken = 1'b0;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy, frame_err, overrun, rx_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rdy;
    logic [7:0] dout;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .clken     (clken),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .dout      (dout),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk_in = ~clk_in;

  // Oversample enable: one pulse every 4 clk_in
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk_in);
      #1;
      div = div + 1;
      clken = ((div % 4) == 0);
    end
  end

  // Monitor: an output event is a rising flag or a new byte while rdy is held
  initial begin
    logic       p_rdy, p_fe, p_ov;
    logic [7:0] p_dout;
    exp_t       e;
    p_rdy = 1'b0; p_fe = 1'b0; p_ov = 1'b0; p_dout = 8'h00;
    forever begin
      @(negedge clk_in);
      if (!rst) begin
        if ((rdy && !p_rdy) || (frame_err && !p_fe) || (overrun && !p_ov) ||
            (rdy && (dout != p_dout))) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got rdy=%b dout=%02h fe=%b ov=%b, none expected",
                     rdy, dout, frame_err, overrun);
          end else begin
            e = sb_q.pop_front();
            if ({rdy, dout, frame_err, overrun} !== e) begin
              errors++;
              $display("FAIL scoreboard: got rdy=%b dout=%02h fe=%b ov=%b want rdy=%b dout=%02h fe=%b ov=%b",
                       rdy, dout, frame_err, overrun, e.rdy, e.dout, e.fe, e.ov);
            end
          end
        end
      end
      p_rdy = rdy; p_fe = frame_err; p_ov = overrun; p_dout = dout;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic [7:0] d, input logic fe, input logic ov);
    exp_t e;
    e.rdy = r; e.dout = d; e.fe = fe; e.ov = ov;
    sb_q.push_back(e);
  endtask

  // Bounded wait for every expected output to have been seen
  task automatic wait_drain(input string name);
    for (int i = 0; i < 800 && sb_q.size() != 0; i++) @(posedge clk_in);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // One 8N1 frame, 64 clk_in per bit, followed by one idle bit time
  task automatic send_frame(input logic [7:0] data, input bit stop_ok);
    @(posedge clk_in);
    #1 rx = 1'b0;
    repeat (64) @(posedge clk_in);
    for (int i = 0; i < 8; i++) begin
      #1 rx = data[i];
      repeat (64) @(posedge clk_in);
    end
    #1;
    if (stop_ok) begin
      rx = 1'b1;
      repeat (64) @(posedge clk_in);
    end else begin
      rx = 1'b0;
      repeat (44) @(posedge clk_in);
      #1 rx = 1'b1;
      repeat (20) @(posedge clk_in);
    end
    #1 rx = 1'b1;
    repeat (64) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_flags();
    @(posedge clk_in);
    #1 rdy_clr = 1'b1;
    @(posedge clk_in);
    #1 rdy_clr = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; rx = 1'b1; rdy_clr = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_fe", 32'(frame_err), 32'h0);
    check("reset_ov", 32'(overrun), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;

    // Stop bit low: frame error, dout and rdy untouched
    push(1'b0, 8'h00, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0);
    wait_drain("t3");
    check("t3_rdy", 32'(rdy), 32'h0);
    check("t3_dout", 32'(dout), 32'h00);
    check("t3_fe", 32'(frame_err), 32'h1);
    check("t3_busy", 32'(rx_busy), 32'h0);
    clear_flags();
    check("t3_fe_cleared", 32'(frame_err), 32'h0);

    // Good frame and its latency bound
    push(1'b1, 8'h55, 1'b0, 1'b0);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk_in);
        repeat (620) @(posedge clk_in);
        #1 check("t1_latency_rdy", 32'(rdy), 32'h1);
      end
    join
    wait_drain("t1");
    check("t1_dout", 32'(dout), 32'h55);
    check("t1_fe", 32'(frame_err), 32'h0);
    clear_flags();
    check("t1_rdy_cleared", 32'(rdy), 32'h0);

    // Short low glitch is rejected at the start-bit midpoint
    @(posedge clk_in);
    #1 rx = 1'b0;
    repeat (16) @(posedge clk_in);
    #1 rx = 1'b1;
    repeat (32) @(posedge clk_in);
    #1;
    check("t2_busy", 32'(rx_busy), 32'h0);
    check("t2_rdy", 32'(rdy), 32'h0);

    // Back-to-back frames without acknowledge: overrun
    push(1'b1, 8'h12, 1'b0, 1'b0);
    push(1'b1, 8'h34, 1'b0, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_drain("t4");
    check("t4_dout", 32'(dout), 32'h34);
    check("t4_rdy", 32'(rdy), 32'h1);
    check("t4_ov", 32'(overrun), 32'h1);
    clear_flags();
    check("t4_rdy_cleared", 32'(rdy), 32'h0);
    check("t4_fe_cleared", 32'(frame_err), 32'h0);
    check("t4_ov_cleared", 32'(overrun), 32'h0);

    // Reset during data bit 3 discards the partial byte
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk_in);
        repeat (64 + 3 * 64 + 32) @(posedge clk_in);
        #1 check("t5_busy_before_rst", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_dout", 32'(dout), 32'h00);
        check("t5_rst_busy", 32'(rx_busy), 32'h0);
        check("t5_rst_rdy", 32'(rdy), 32'h0);
        @(posedge clk_in);
        #1 rst = 1'b0;
      end
    join
    check("t5_idle_after", 32'(rx_busy), 32'h0);
    push(1'b1, 8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1);
    wait_drain("t5");
    check("t5_dout", 32'(dout), 32'hC3);
    check("t5_rdy", 32'(rdy), 32'h1);

    // Acknowledge in the completion cycle: set wins, no overrun
    push(1'b1, 8'h7E, 1'b0, 1'b0);
    found = 1'b0;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        for (int i = 0; i < 200; i++) begin
          @(posedge clk_in);
          #1;
          if (rx_busy) begin
            found = 1'b1;
            break;
          end
        end
        check("t6_busy_seen", 32'(found), 32'h1);
        if (found) begin
          repeat (607) @(posedge clk_in);
          #1 rdy_clr = 1'b1;
          @(posedge clk_in);
          #1 rdy_clr = 1'b0;
          check("t6_rdy", 32'(rdy), 32'h1);
          check("t6_ov", 32'(overrun), 32'h0);
          check("t6_dout", 32'(dout), 32'h7E);
        end
      end
    join
    wait_drain("t6");

    repeat (10) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
